fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
// Fetch-stage PC owner and instruction fetcher. Holds PCF and drives PCPlus4F to the next-PC mux.
// Takes the mux result back as PCF_bar, and takes PCSrcE as the redirect strobe.
// Issues single-outstanding requests to instruction memory and buffers the returned words in a small FIFO.
// Presents {InstrD, PCD, PCPlus4D} to decode over a valid/ready handshake.
// PARAMETERS
// RESET_PC    32'h0000_0000  PCF value after reset
// FIFO_DEPTH  2              instruction buffer entries; power of 2, >=2
// PORTS
// clk          in   1   clock, rising edge
// rst_n        in   1   async active-low reset
// PCF_bar      in   32  next PC from mux (PCTargetE if PCSrcE else PCPlus4F)
// PCSrcE       in   1   redirect: branch/jump taken in execute
// PCF          out  32  current fetch PC (register)
// PCPlus4F     out  32  PCF + 4, combinational
// imem_req     out  1   fetch request valid
// imem_addr    out  32  fetch address (= PCF)
// imem_gnt     in   1   request accepted this cycle
// imem_rvalid  in   1   read data valid (>=1 cycle after gnt)
// imem_rdata   in   32  instruction word
// instr_valid  out  1   FIFO head valid
// instr_ready  in   1   decode accepts head
// InstrD       out  32  head instruction
// PCD          out  32  head PC
// PCPlus4D     out  32  head PC+4
// BEHAVIOUR
// - Reset (async, any state): PCF=RESET_PC; FIFO empty; state IDLE.
//   Outputs: imem_req=0, instr_valid=0, InstrD/PCD/PCPlus4D=0.
// - PCPlus4F = PCF+4 mod 2^32. 32'hFFFF_FFFC wraps to 0.
// - PCF <= PCF_bar when (imem_req & imem_gnt) or PCSrcE; otherwise PCF holds.
// - FSM states IDLE/REQ/WAIT/DROP. imem_req=1 only in REQ. Max one outstanding request.
//   IDLE: -> REQ if count<FIFO_DEPTH.
//   REQ:  req/addr held until gnt; on gnt -> WAIT.
//   WAIT: on rvalid, push {rdata, addr of request, addr+4}.
//         -> REQ if count_next<FIFO_DEPTH, else IDLE.
//   DROP: on rvalid, discard data -> IDLE.
// - FIFO push only from WAIT on rvalid. Pop on instr_valid & instr_ready.
//   Push+pop in the same cycle leaves count unchanged. Pop when empty never occurs.
//   Full FIFO: no request issued; space is reserved before issue, so rvalid never meets a full FIFO.
// - Head outputs are held stable while instr_valid & !instr_ready.
// - Redirect (PCSrcE=1) has priority over all other events:
//   FIFO flushed (count=0); any pop or push that cycle is discarded; next cycle instr_valid=0.
//   IDLE: stay IDLE.
//   REQ, no gnt: stay REQ; imem_addr = new PCF next cycle (address change permitted only on redirect).
//   REQ with gnt same cycle: granted fetch is stale -> DROP.
//   WAIT, no rvalid: -> DROP.
//   WAIT with rvalid: data discarded -> IDLE.
//   DROP: stay DROP.
// - Latency: request issue to instr_valid = gnt wait + rvalid wait + 1 cycle.
//   Throughput with 1-cycle gnt/rvalid: one instruction per 2 cycles.
// - imem_rvalid outside WAIT/DROP is ignored. imem_gnt outside REQ is ignored.
// TESTING
// - Reset mid-run with FIFO full: rst_n=0 -> same cycle imem_req=0, instr_valid=0.
//   After release: PCF=0, imem_addr=0.
// - Sequential fetch, gnt/rvalid 1 cycle, ready=1, words A,B,C:
//   decode sees (A,PCD=0), (B,4), (C,8) in order; PCPlus4D=PCD+4.
// - Backpressure, ready=0, depth 2: after 2 pushes imem_req stays 0 and the head holds A.
//   ready=1 for 1 cycle -> A popped, next request at PC=8.
// - Redirect in WAIT, PCSrcE=1 with PCF_bar=0x100: next instr_valid=0.
//   Stale rvalid data is dropped; next request addr=0x100; first delivered PCD=0x100.
// - Redirect coincident with gnt at PC=4: -> DROP, PCF=target.
//   Following rvalid is discarded; the target fetch then completes.
// - Wrap: RESET_PC=32'hFFFF_FFFC -> PCPlus4F=0; the second fetch addr=0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC owner and instruction fetcher.
//   Holds PCF and drives PCPlus4F to the external next-PC mux, whose result
//   returns as PCF_bar. Issues at most one outstanding instruction-memory
//   request and buffers returned words in a small FIFO. The FIFO head goes to
//   decode over a valid/ready handshake. PCSrcE is the redirect strobe: it
//   flushes the buffer and retires any in-flight fetch.
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   PCF_bar, PCSrcE                 next PC from the mux, redirect strobe
//   PCF, PCPlus4F                   current fetch PC, PCF+4
//   imem_req/addr/gnt               request channel to instruction memory
//   imem_rvalid/rdata               response channel from instruction memory
//   instr_valid/ready               decode handshake
//   InstrD, PCD, PCPlus4D           FIFO head (zero while the FIFO is empty)
//
// state | meaning
// IDLE  | no request in flight; leave once the FIFO has room
// REQ   | imem_req high at PCF, waiting for gnt
// WAIT  | granted, waiting for rvalid; the word is pushed on arrival
// DROP  | granted fetch went stale after a redirect; its word is discarded
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF_bar,
  input  logic        PCSrcE,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t          state;
  logic [31:0]     req_pc;
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [31:0]     fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            gnt_ok;
  logic            push;
  logic            pop;

  assign PCPlus4F    = PCF + 32'd4;
  assign imem_req    = (state == REQ);
  assign imem_addr   = PCF;
  assign gnt_ok      = imem_req & imem_gnt;
  assign instr_valid = (count != '0);

  // A redirect cancels whatever push or pop would have happened this cycle.
  assign push       = (state == WAIT) & imem_rvalid & ~PCSrcE;
  assign pop        = instr_valid & instr_ready & ~PCSrcE;
  assign count_next = count + CW'(push) - CW'(pop);

  assign InstrD   = instr_valid ? fifo_instr[rd_ptr]       : '0;
  assign PCD      = instr_valid ? fifo_pc[rd_ptr]          : '0;
  assign PCPlus4D = instr_valid ? fifo_pc[rd_ptr] + 32'd4  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCF <= RESET_PC;
    end else if (gnt_ok || PCSrcE) begin
      PCF <= PCF_bar;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!PCSrcE && (count < CW'(FIFO_DEPTH))) state <= REQ;
        end
        REQ: begin
          if (imem_gnt) begin
            req_pc <= PCF;
            state  <= PCSrcE ? DROP : WAIT;
          end
        end
        WAIT: begin
          // Space was reserved before issue, so count_next never exceeds depth.
          if (imem_rvalid) begin
            state <= (!PCSrcE && (count_next < CW'(FIFO_DEPTH))) ? REQ : IDLE;
          end else if (PCSrcE) begin
            state <= DROP;
          end
        end
        DROP: begin
          // The single stale response retires the drop, redirect or not.
          if (imem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (PCSrcE) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  // Storage needs no reset: the head outputs are gated by instr_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed and randomized checks of fetch_pc_unit against a
// behavioural model: decode must see consecutive PCs starting from reset or the
// latest redirect target, each carrying the memory word stored at that PC.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] PCF_bar = '0;
  logic        PCSrcE = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic [31:0] PCF, PCPlus4F, imem_addr, InstrD, PCD, PCPlus4D;
  logic        imem_req, instr_valid;

  // Second instance for the address-wrap case.
  logic [31:0] w_pcf, w_pcplus4f, w_imem_addr, w_instrd, w_pcd, w_pcplus4d;
  logic        w_imem_req, w_instr_valid;
  logic        w_gnt = 1'b0, w_rvalid = 1'b0, w_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .PCF_bar(PCF_bar), .PCSrcE(PCSrcE),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .PCF_bar(w_pcplus4f), .PCSrcE(1'b0),
    .PCF(w_pcf), .PCPlus4F(w_pcplus4f), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(32'h0BAD_F00D),
    .instr_valid(w_instr_valid), .instr_ready(w_ready),
    .InstrD(w_instrd), .PCD(w_pcd), .PCPlus4D(w_pcplus4d)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic [31:0] exp_pc, fetch_pc, pend_addr, last_pcd, held_instr, held_pcd;
  bit          pending, held;
  int          delivered = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit rdy, input bit gnt_en, input bit rv_en,
                      input bit redir, input logic [31:0] tgt);
    chk("pcplus4f", PCPlus4F, PCF + 32'd4);
    if (imem_req) chk("imem_addr", imem_addr, fetch_pc);
    if (held) begin
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", InstrD, held_instr);
      chk("hold_pcd", PCD, held_pcd);
    end

    instr_ready = rdy;
    imem_gnt    = gnt_en && imem_req;
    imem_rvalid = rv_en && pending;
    imem_rdata  = imem_rvalid ? word_at(pend_addr) : 32'hDEAD_BEEF;
    PCSrcE      = redir;
    PCF_bar     = redir ? tgt : PCPlus4F;

    if (instr_valid && rdy && !redir) begin
      chk("instr", InstrD, word_at(exp_pc));
      chk("pcd", PCD, exp_pc);
      chk("pcplus4d", PCPlus4D, exp_pc + 32'd4);
      last_pcd = PCD;
      exp_pc   = exp_pc + 32'd4;
      delivered++;
    end
    held = instr_valid && !rdy && !redir;
    held_instr = InstrD;
    held_pcd   = PCD;

    if (imem_rvalid) pending = 1'b0;
    if (imem_req && imem_gnt) begin
      pending   = 1'b1;
      pend_addr = imem_addr;
    end
    if (redir) begin
      exp_pc   = tgt;
      fetch_pc = tgt;
    end else if (imem_req && imem_gnt) begin
      fetch_pc = fetch_pc + 32'd4;
    end

    @(posedge clk); #1;
  endtask

  task automatic run_until(input int n, input int budget);
    int start;
    int k;
    start = delivered;
    k = 0;
    while (delivered < start + n && k < budget) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      k++;
    end
    chk("deliver_timeout", 32'(delivered >= start + n), 32'd1);
  endtask

  // Entered at posedge+1; asserts reset immediately and leaves at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    PCSrcE = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    #1;
    PCF_bar = PCPlus4F;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", InstrD, 32'd0);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcp4d", PCPlus4D, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_pcf", PCF, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    exp_pc = '0; fetch_pc = '0; pending = 1'b0; held = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Address wrap at the top of the address space.
    chk("wrap_p4f", w_pcplus4f, 32'd0);
    chk("wrap_req", 32'(w_imem_req), 32'd1);
    chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
    w_gnt = 1'b1; w_rvalid = 1'b1; w_ready = 1'b1;
    @(posedge clk); #1;
    chk("wrap_pcf", w_pcf, 32'd0);
    @(posedge clk); #1;
    w_gnt = 1'b0; w_rvalid = 1'b0;
    chk("wrap_req2", 32'(w_imem_req), 32'd1);
    chk("wrap_addr1", w_imem_addr, 32'd0);
    chk("wrap_pcd", w_pcd, 32'hFFFF_FFFC);
    chk("wrap_pcp4d", w_pcplus4d, 32'd0);

    // Sequential fetch, single-cycle memory, decode always ready.
    do_reset();
    run_until(3, 30);
    chk("seq_last_pcd", last_pcd, 32'd8);

    // Backpressure: two buffered words stop further requests.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_pcd", PCD, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    begin
      int k;
      k = 0;
      while (!imem_req && k < 5) begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        k++;
      end
    end
    chk("bp_req_again", 32'(imem_req), 32'd1);
    chk("bp_next_addr", imem_addr, 32'd8);
    chk("bp_head_b", PCD, 32'd4);

    // Redirect while waiting for read data.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    chk("rw_valid", 32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("rw_valid2", 32'(instr_valid), 32'd0);
    run_until(1, 20);
    chk("rw_first_pcd", last_pcd, 32'h100);

    // Redirect coincident with grant at PC=4.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("rg_addr4", imem_addr, 32'd4);
    chk("rg_req", 32'(imem_req), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    chk("rg_pcf", PCF, 32'h200);
    chk("rg_valid", 32'(instr_valid), 32'd0);
    chk("rg_noreq", 32'(imem_req), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    run_until(2, 20);
    chk("rg_pcd", last_pcd, 32'h204);

    // Randomized traffic with occasional redirects.
    begin
      int start;
      start = delivered;
      for (int i = 0; i < 400; i++) begin
        step(($urandom % 4) != 0, ($urandom % 2) == 0, ($urandom % 2) == 0,
             ($urandom % 16) == 0, 32'($urandom_range(0, 1023)) << 2);
      end
      chk("rand_progress", 32'(delivered - start > 20), 32'd1);
    end

    // Fill the buffer, then reset mid-run.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_req", 32'(imem_req), 32'd0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
